// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - immediate-field encoder: rotated 8-bit search, 12-bit and 24-bit branch range checks
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Value,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [23:0] Instr
);

  typedef enum logic [1:0] {IDLE, SEARCH, CHECK, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] val;
  logic [1:0]  src;
  logic [3:0]  r;
  logic [63:0] dbl;
  logic [31:0] cand;
  logic        hit;
  logic        chk_ok;
  logic [23:0] chk_instr;

  // Rotate-left by 2*r: upper half of the doubled word shifted left.
  assign dbl  = {val, val} << {r, 1'b0};
  assign cand = dbl[63:32];
  assign hit  = (cand[31:8] == 24'd0);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    chk_ok    = 1'b0;
    chk_instr = 24'd0;
    case (src)
      2'b01: begin
        chk_ok    = (val[31:12] == 20'd0);
        chk_instr = {12'd0, val[11:0]};
      end
      2'b10: begin
        chk_ok    = (val[1:0] == 2'b00) && ((val[31:25] == 7'h00) || (val[31:25] == 7'h7F));
        chk_instr = val[25:2];
      end
      default: begin
        chk_ok    = 1'b0;
        chk_instr = 24'd0;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (ImmSrc == 2'b00) ? SEARCH : CHECK;
      SEARCH:  if (hit || (r == 4'd15)) state_next = DONE;
      CHECK:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      val   <= 32'd0;
      src   <= 2'b00;
      r     <= 4'd0;
      ok    <= 1'b0;
      Instr <= 24'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            val <= Value;
            src <= ImmSrc;
            r   <= 4'd0;
          end
        end
        SEARCH: begin
          if (hit) begin
            ok    <= 1'b1;
            Instr <= {12'd0, r, cand[7:0]};
          end else if (r == 4'd15) begin
            ok    <= 1'b0;
            Instr <= 24'd0;
          end else begin
            r <= r + 4'd1;
          end
        end
        CHECK: begin
          ok    <= chk_ok;
          Instr <= chk_ok ? chk_instr : 24'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 ImmSrc  input  2  immediate format: 00 rotated 8-bit, 01 12-bit unsigned, 10 24-bit branch offset, 11 reserved.
REQ-006 Value  input  32  full-width value to be encoded; sampled with start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 ok  output  1  registered; 1 = Value is encodable in the requested format.
REQ-010 Instr  output  24  registered instruction immediate field, Instr[23:0].

Function
REQ-011 SHALL implement FSM states IDLE, SEARCH, CHECK, DONE.
REQ-012 IDLE + start: latch Value and ImmSrc; ImmSrc=00 -> SEARCH with rotation counter r=0; any other ImmSrc -> CHECK.
REQ-013 start outside IDLE (SEARCH, CHECK, DONE) SHALL be ignored; Value/ImmSrc changes after the start cycle SHALL have no effect.
REQ-014 SEARCH, one rotation per cycle: candidate c = latched Value rotated left by 2*r; hit when c[31:8]==0.
REQ-015 SEARCH hit: Instr={12'b0, r[3:0], c[7:0]}, ok=1, -> DONE; lowest hitting r SHALL win.
REQ-016 SEARCH miss with r<15: r=r+1, stay in SEARCH; miss with r==15: Instr=0, ok=0, -> DONE.
REQ-017 CHECK, ImmSrc=01: ok=1 iff Value[31:12]==0; Instr={12'b0, Value[11:0]}.
REQ-018 CHECK, ImmSrc=10: ok=1 iff Value[1:0]==0 and Value[31:25] all equal Value[25]; Instr=Value[25:2].
REQ-019 CHECK, ImmSrc=11: ok=0, Instr=0.
REQ-020 Any CHECK with ok=0: Instr=0; CHECK SHALL take exactly one cycle, then -> DONE.
REQ-021 DONE: done=1 for exactly that cycle, then -> IDLE unconditionally.
REQ-022 Latency, with start sampled in cycle 0: ImmSrc 01/10/11 -> done in cycle 2; ImmSrc 00 with winning rotation r -> done in cycle r+2; 00 with no fit -> done in cycle 17.
REQ-023 ok and Instr SHALL update only on leaving SEARCH/CHECK and hold until the next accepted start's result.
REQ-024 Value=0 with ImmSrc=00 SHALL hit at r=0: ok=1, Instr=0.
REQ-025 Back-to-back: a start asserted in the cycle after done (IDLE) SHALL be accepted.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, r=0, busy=0, done=0, ok=0, Instr=0.
REQ-027 reset SHALL take priority over start and over any in-progress SEARCH/CHECK; the aborted request produces no done.
REQ-028 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-029 ImmSrc=00, Value=32'h00000009 -> done cycle 2, ok=1, Instr=24'h000009.
REQ-030 ImmSrc=00, Value=32'hFF000000 -> done cycle 6, ok=1, Instr=24'h0004FF.
REQ-031 ImmSrc=00, Value=32'h00000101 -> done cycle 17, ok=0, Instr=0; busy high cycles 1-17.
REQ-032 ImmSrc=01, Value=32'h00000ABC -> done cycle 2, ok=1, Instr=24'h000ABC; Value=32'h00001000 -> ok=0, Instr=0.
REQ-033 ImmSrc=10: Value=32'hFFFFFFF8 -> ok=1, Instr=24'hFFFFFE; Value=32'h00000006 -> ok=0; Value=32'h02000000 -> ok=0.
REQ-034 Reset mid-operation: ImmSrc=00, Value=32'h00000101, reset in cycle 5 -> IDLE, all outputs 0, no done pulse. Start during SEARCH -> ignored.
